// File: rtl/ysyx_23060077_ifu_fetchq.sv
// Instruction fetch unit: single-outstanding I-cache requester feeding an in-order fetch queue.
// Define YSYX_23060077_IFU_JAL_PRED_EN to follow JAL targets at fetch and mark them predicted-taken.
module ysyx_23060077_ifu_fetchq #(
   parameter int          FQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        redirect_valid_i,
   input  logic [31:0]                 redirect_pc_i,
   output logic                        if_to_id_valid_o,
   input  logic                        if_to_id_ready_i,
   output logic [31:0]                 ifu_pc_o,
   output logic [31:0]                 ifu_inst_o,
   output logic                        ifu_pred_taken_o,
   output logic [$clog2(FQ_DEPTH):0]   ifu_fq_count_o,
   output logic                        Icache_valid_o,
   output logic [31:0]                 Icache_addr_o,
   input  logic                        Icache_ready_i,
   input  logic [31:0]                 Icache_data_i
);

   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(FQ_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t        r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_addr;
   logic          r_icv;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [31:0]   r_q_pc   [FQ_DEPTH];
   logic [31:0]   r_q_inst [FQ_DEPTH];

   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_cnt_nxt;
   logic [31:0]   w_next_pc;
   logic          w_pred;

   // Redirect wins over everything: no push, no pop, queue emptied.
   assign w_push    = (r_state == S_WAIT) & Icache_ready_i & ~redirect_valid_i;
   assign w_pop     = (r_count != '0) & if_to_id_ready_i & ~redirect_valid_i;
   assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

`ifdef YSYX_23060077_IFU_JAL_PRED_EN
   logic          r_q_pred [FQ_DEPTH];
   logic          w_is_jal;
   logic [31:0]   w_jal_imm;

   assign w_is_jal  = (Icache_data_i[6:0] == 7'b1101111);
   assign w_jal_imm = {{11{Icache_data_i[31]}}, Icache_data_i[31], Icache_data_i[19:12],
                       Icache_data_i[20], Icache_data_i[30:21], 1'b0};
   assign w_next_pc = r_pc + (w_is_jal ? w_jal_imm : 32'd4);
   assign w_pred    = w_is_jal;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FQ_DEPTH; i++) r_q_pred[i] <= 1'b0;
      end else if (w_push) begin
         r_q_pred[r_tail] <= w_pred;
      end
   end

   assign ifu_pred_taken_o = r_q_pred[r_head];
`else
   assign w_next_pc        = r_pc + 32'd4;
   assign w_pred           = 1'b0;
   assign ifu_pred_taken_o = w_pred;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FQ_DEPTH; i++) begin
            r_q_pc[i]   <= '0;
            r_q_inst[i] <= '0;
         end
      end else if (w_push) begin
         r_q_pc[r_tail]   <= r_pc;
         r_q_inst[r_tail] <= Icache_data_i;
      end
   end

   // Pointers are PW bits wide, so wrap modulo FQ_DEPTH comes for free.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect_valid_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         r_count <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
         r_icv   <= 1'b0;
      end else if (redirect_valid_i) begin
         r_pc <= redirect_pc_i;
         // An unanswered request must still be drained before a new one may issue.
         if (r_state != S_IDLE && !Icache_ready_i) begin
            r_state <= S_DROP;
            r_icv   <= 1'b1;
         end else begin
            r_state <= S_IDLE;
            r_icv   <= 1'b0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_count < DEPTH) begin
                  r_state <= S_WAIT;
                  r_icv   <= 1'b1;
                  r_addr  <= r_pc;
               end
            end
            S_WAIT: begin
               if (Icache_ready_i) begin
                  r_pc <= w_next_pc;
                  if (w_cnt_nxt < DEPTH) begin
                     r_addr <= w_next_pc;
                  end else begin
                     r_state <= S_IDLE;
                     r_icv   <= 1'b0;
                  end
               end
            end
            S_DROP: begin
               if (Icache_ready_i) begin
                  r_state <= S_IDLE;
                  r_icv   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_icv   <= 1'b0;
            end
         endcase
      end
   end

   assign if_to_id_valid_o = (r_count != '0);
   assign ifu_pc_o         = r_q_pc[r_head];
   assign ifu_inst_o       = r_q_inst[r_head];
   assign ifu_fq_count_o   = r_count;
   assign Icache_valid_o   = r_icv;
   assign Icache_addr_o    = r_addr;

endmodule

// File: tb/tb_ysyx_23060077_ifu_fetchq.sv
// Scoreboard bench for the fetch queue: expected entries are queued as the I-cache answers,
// a negedge monitor compares the queue head, occupancy and request address every cycle.
module tb_ysyx_23060077_ifu_fetchq;

   localparam logic [31:0] RST_PC = 32'h3000_0000;
`ifdef YSYX_23060077_IFU_JAL_PRED_EN
   localparam logic [31:0] EXP_A1   = 32'h3000_0010;
   localparam logic        EXP_PRED = 1'b1;
`else
   localparam logic [31:0] EXP_A1   = 32'h3000_0004;
   localparam logic        EXP_PRED = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        if_to_id_ready_i = 1'b0;
   logic        Icache_ready_i = 1'b0;
   logic [31:0] Icache_data_i = '0;
   logic        if_to_id_valid_o;
   logic [31:0] ifu_pc_o;
   logic [31:0] ifu_inst_o;
   logic        ifu_pred_taken_o;
   logic [2:0]  ifu_fq_count_o;
   logic        Icache_valid_o;
   logic [31:0] Icache_addr_o;

   ysyx_23060077_ifu_fetchq #(.FQ_DEPTH(4), .RESET_PC(RST_PC)) dut (
      .clock(clock), .reset(reset),
      .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
      .if_to_id_valid_o(if_to_id_valid_o), .if_to_id_ready_i(if_to_id_ready_i),
      .ifu_pc_o(ifu_pc_o), .ifu_inst_o(ifu_inst_o), .ifu_pred_taken_o(ifu_pred_taken_o),
      .ifu_fq_count_o(ifu_fq_count_o),
      .Icache_valid_o(Icache_valid_o), .Icache_addr_o(Icache_addr_o),
      .Icache_ready_i(Icache_ready_i), .Icache_data_i(Icache_data_i)
   );

   always #5 clock = ~clock;

   typedef struct {logic [31:0] pc; logic [31:0] inst; logic pred;} ent_t;

   ent_t        q[$];
   logic [31:0] addr_log[$];
   logic [31:0] exp_pc = RST_PC;
   bit          drop = 0;
   bit          chk_en = 0;
   bit          mem_en = 0;
   int          mem_lat = 1;
   int          mw = 0;
   int          n_resp = 0;
   int          cyc = 0;
   int          t_req = -1;
   int          t_vld = -1;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h3000_0000) return 32'h0100_006F;
      return {a[24:0] ^ 25'h1A5_A5A5, 7'h13};
   endfunction

   function automatic logic [32:0] next_of(input logic [31:0] pc, input logic [31:0] inst);
`ifdef YSYX_23060077_IFU_JAL_PRED_EN
      if (inst[6:0] == 7'h6F)
         return {1'b1, pc + {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}};
`endif
      return {1'b0, pc + 32'd4};
   endfunction

   // Memory: answers a pending request mem_lat cycles after first seeing it.
   always begin
      @(posedge clock);
      #2;
      if (mem_en) begin
         Icache_ready_i = 1'b0;
         if (Icache_valid_o && reset) begin
            if (mw >= mem_lat) begin
               Icache_ready_i = 1'b1;
               Icache_data_i  = mem_rd(Icache_addr_o);
               mw = 0;
               n_resp++;
            end else mw++;
         end else mw = 0;
      end
   end

   // Monitor + scoreboard model: compare current outputs, then apply this cycle's inputs.
   always @(negedge clock) begin
      if (chk_en) begin
         ent_t        e;
         logic [32:0] nx;
         cyc++;
         check("count", ifu_fq_count_o, q.size());
         check("id_valid", if_to_id_valid_o, q.size() != 0);
         if (q.size() != 0) begin
            check("head_pc", ifu_pc_o, q[0].pc);
            check("head_inst", ifu_inst_o, q[0].inst);
            check("head_pred", ifu_pred_taken_o, q[0].pred);
         end
         if (Icache_valid_o && t_req < 0) t_req = cyc;
         if (if_to_id_valid_o && t_vld < 0) begin
            t_vld = cyc;
            check("first_inst", ifu_inst_o, 32'h0100_006F);
            check("first_pred", ifu_pred_taken_o, EXP_PRED);
         end
         if (redirect_valid_i) begin
            q.delete();
            exp_pc = redirect_pc_i;
            drop   = Icache_valid_o && !Icache_ready_i;
         end else begin
            if (q.size() != 0 && if_to_id_ready_i) void'(q.pop_front());
            if (Icache_valid_o && Icache_ready_i) begin
               if (drop) drop = 0;
               else begin
                  check("icache_addr", Icache_addr_o, exp_pc);
                  addr_log.push_back(Icache_addr_o);
                  nx     = next_of(exp_pc, Icache_data_i);
                  e.pc   = exp_pc;
                  e.inst = Icache_data_i;
                  e.pred = nx[32];
                  q.push_back(e);
                  exp_pc = nx[31:0];
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_icv(input int lim);
      bit ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         tick();
         if (Icache_valid_o) ok = 1;
      end
      check("wait_icache_valid", ok, 1);
   endtask

   initial begin
      int n0;
      #1 reset = 1'b0;
      #2;
      check("rst_id_valid", if_to_id_valid_o, 0);
      check("rst_pc", ifu_pc_o, 0);
      check("rst_inst", ifu_inst_o, 0);
      check("rst_pred", ifu_pred_taken_o, 0);
      check("rst_count", ifu_fq_count_o, 0);
      check("rst_icache_valid", Icache_valid_o, 0);
      check("rst_icache_addr", Icache_addr_o, RST_PC);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      chk_en = 1;

      // Streaming fetch with decode always ready.
      if_to_id_ready_i = 1'b1;
      mem_en = 1;
      repeat (12) tick();
      check("log_len", addr_log.size() >= 3, 1);
      check("addr0", addr_log[0], RST_PC);
      check("addr1", addr_log[1], EXP_A1);
      check("addr2", addr_log[2], EXP_A1 + 32'd4);
      check("req_to_valid", t_vld - t_req, 2);

      // Back-pressure fills the queue, then one pop allows exactly one refill.
      if_to_id_ready_i = 1'b0;
      repeat (20) tick();
      check("full_count", ifu_fq_count_o, 4);
      check("full_idle", Icache_valid_o, 0);
      n0 = n_resp;
      if_to_id_ready_i = 1'b1;
      tick();
      if_to_id_ready_i = 1'b0;
      @(negedge clock);
      check("after_pop_count", ifu_fq_count_o, 3);
      repeat (10) tick();
      check("refill_reqs", n_resp - n0, 1);
      check("refill_count", ifu_fq_count_o, 4);
      check("refill_idle", Icache_valid_o, 0);

      // Redirect while a request is outstanding: late response is dropped.
      mem_en = 0;
      Icache_ready_i = 1'b0;
      if_to_id_ready_i = 1'b1;
      wait_icv(10);
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h8000_0100;
      tick();
      redirect_valid_i = 1'b0;
      check("drop_valid", Icache_valid_o, 1);
      check("drop_count", ifu_fq_count_o, 0);
      repeat (2) tick();
      Icache_ready_i = 1'b1;
      Icache_data_i = 32'h0000_0013;
      tick();
      Icache_ready_i = 1'b0;
      check("dropped_count", ifu_fq_count_o, 0);
      check("dropped_idle", Icache_valid_o, 0);
      tick();
      check("redir_valid", Icache_valid_o, 1);
      check("redir_addr", Icache_addr_o, 32'h8000_0100);

      // Redirect coincident with response and pop.
      if_to_id_ready_i = 1'b0;
      Icache_ready_i = 1'b1;
      Icache_data_i = 32'h0010_0093;
      tick();
      Icache_data_i = 32'h1111_1113;
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h9000_0000;
      if_to_id_ready_i = 1'b1;
      @(negedge clock);
      check("pre_coinc_count", ifu_fq_count_o, 1);
      tick();
      Icache_ready_i = 1'b0;
      redirect_valid_i = 1'b0;
      check("coinc_count", ifu_fq_count_o, 0);
      check("coinc_idle", Icache_valid_o, 0);
      check("coinc_id_valid", if_to_id_valid_o, 0);
      tick();
      check("coinc_valid", Icache_valid_o, 1);
      check("coinc_addr", Icache_addr_o, 32'h9000_0000);

      // Redirect near the top of the address space: fetch pc wraps to zero.
      addr_log.delete();
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFF8;
      mem_en = 1;
      tick();
      redirect_valid_i = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if_to_id_ready_i = (i % 3) != 0;
         tick();
      end
      if_to_id_ready_i = 1'b1;
      check("wrap_len", addr_log.size() >= 3, 1);
      check("wrap0", addr_log[0], 32'hFFFF_FFF8);
      check("wrap1", addr_log[1], 32'hFFFF_FFFC);
      check("wrap2", addr_log[2], 32'h0000_0000);

      // Reset mid-request abandons it immediately.
      mem_en = 0;
      Icache_ready_i = 1'b0;
      wait_icv(10);
      #2;
      chk_en = 0;
      reset = 1'b0;
      #1;
      check("mid_rst_icv", Icache_valid_o, 0);
      check("mid_rst_addr", Icache_addr_o, RST_PC);
      check("mid_rst_count", ifu_fq_count_o, 0);
      check("mid_rst_pc", ifu_pc_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ysyx_23060077_ifu_fetchq.md
YSYX_23060077_IFU_FETCHQ -- requirements
Module: ysyx_23060077_ifu_fetchq

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h3000_0000, first fetch address after reset.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports redirect_valid_i  input  1 and redirect_pc_i  input  32: flush and restart fetch at redirect_pc_i.
REQ-006 SHALL have ports if_to_id_valid_o  output  1 and if_to_id_ready_i  input  1: decode handshake.
REQ-007 SHALL have ports ifu_pc_o  output  32, ifu_inst_o  output  32 and ifu_pred_taken_o  output  1: queue-head entry.
REQ-008 SHALL have port ifu_fq_count_o  output  clog2(FQ_DEPTH)+1  current occupancy.
REQ-009 SHALL have ports Icache_valid_o  output  1, Icache_addr_o  output  32, Icache_ready_i  input  1 (response strobe) and Icache_data_i  input  32.

Function
REQ-010 SHALL implement FSM IDLE / WAIT / DROP; Icache_valid_o=1 exactly in WAIT and DROP.
REQ-011 SHALL hold Icache_addr_o and Icache_valid_o stable from entry to WAIT/DROP until the cycle Icache_ready_i=1 (max one outstanding request).
REQ-012 IDLE: no redirect and count<FQ_DEPTH -> WAIT next cycle with Icache_addr_o<=fetch pc.
REQ-013 WAIT, Icache_ready_i=1, no redirect: push {pc, Icache_data_i, pred} at tail; fetch pc<=next pc; stay WAIT with new addr if post-update count<FQ_DEPTH, else IDLE.
REQ-014 Next pc SHALL be pc+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000) unless REQ-026 applies.
REQ-015 if_to_id_valid_o SHALL equal (count!=0); head fields drive ifu_pc_o/ifu_inst_o/ifu_pred_taken_o combinationally.
REQ-016 Pop SHALL occur when if_to_id_valid_o & if_to_id_ready_i; push and pop in one cycle leave count unchanged; pointers wrap modulo FQ_DEPTH.
REQ-017 Push SHALL never occur with count==FQ_DEPTH (guaranteed by REQ-012/013).
REQ-018 Redirect SHALL have priority over push, pop and state transitions: count<=0, pointers<=0, fetch pc<=redirect_pc_i, same-cycle pop ignored.
REQ-019 Redirect in WAIT without Icache_ready_i -> DROP; in-flight response discarded.
REQ-020 Redirect coincident with Icache_ready_i (WAIT or DROP) -> IDLE; response discarded.
REQ-021 DROP: Icache_ready_i=1 -> IDLE, data discarded, no push; further redirect in DROP updates pc, stays DROP.
REQ-022 Redirect in IDLE SHALL stay IDLE; next fetch issues from redirect_pc_i one cycle later.
REQ-023 Latency: response pushed at edge N SHALL be visible at outputs after edge N (if_to_id_valid_o=1 in cycle N+1).

Reset
REQ-024 On reset low, asynchronously: state IDLE, fetch pc=RESET_PC, count=0, pointers=0, all queue entries zeroed.
REQ-025 Reset outputs: if_to_id_valid_o=0, ifu_pc_o=0, ifu_inst_o=0, ifu_pred_taken_o=0, ifu_fq_count_o=0, Icache_valid_o=0, Icache_addr_o=RESET_PC; reset mid-request abandons it without waiting for Icache_ready_i.

Configuration
REQ-026 With YSYX_23060077_IFU_JAL_PRED_EN defined: when Icache_data_i[6:0]==7'b1101111, next pc SHALL be pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}) modulo 2^32 and pushed pred bit=1.
REQ-027 Without YSYX_23060077_IFU_JAL_PRED_EN: next pc always pc+4, pred bit and ifu_pred_taken_o constant 0, no decode logic present.

Verification
REQ-028 Reset release, Icache 1-cycle responses, decode always ready -> addresses 0x3000_0000, _0004, _0008 in order; if_to_id_valid_o first 1 two cycles after first Icache_valid_o.
REQ-029 Decode ready=0, FQ_DEPTH=4 -> exactly 4 pushes, ifu_fq_count_o=4, Icache_valid_o=0 (IDLE); ready=1 one cycle -> count 3, one new request issued.
REQ-030 Redirect to 0x8000_0100 while WAIT, response 3 cycles later -> response dropped, count=0, next Icache_addr_o=0x8000_0100.
REQ-031 Redirect coincident with Icache_ready_i and a pop -> count=0, no push, state IDLE, next request at redirect pc.
REQ-032 With YSYX_23060077_IFU_JAL_PRED_EN, inst 0x0100006F at 0x3000_0000 -> ifu_pred_taken_o=1, next addr 0x3000_0010; without macro next addr 0x3000_0004, pred 0.
